// File: rtl/axil_csr_pkg.sv
// Shared definitions for the AXI4-Lite CSR slave: register map, response codes,
// channel FSM encodings and the byte-strobe merge helper.
package axil_csr_pkg;

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_STATUS   = 12'h004;
  localparam logic [11:0] OFF_IRQ_EN   = 12'h008;
  localparam logic [11:0] OFF_ID       = 12'h00C;
  localparam logic [11:0] OFF_CFG_BASE = 12'h010;

  // Word indices derived from the byte offsets (addr[1:0] is ignored)
  localparam int unsigned IDX_CTRL     = 32'(OFF_CTRL >> 2);
  localparam int unsigned IDX_STATUS   = 32'(OFF_STATUS >> 2);
  localparam int unsigned IDX_IRQ_EN   = 32'(OFF_IRQ_EN >> 2);
  localparam int unsigned IDX_ID       = 32'(OFF_ID >> 2);
  localparam int unsigned IDX_CFG_BASE = 32'(OFF_CFG_BASE >> 2);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_ADDR = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_csr_wr_ctrl.sv
// AXI4-Lite write channel: joins AW and W in either order, emits a one-cycle
// commit strobe with index/data/strobe, and holds the B response until bready.
module axil_csr_wr_ctrl
  import axil_csr_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                commit_o,
  output logic [ADDR_W-3:0]   cm_idx_o,
  output logic [DATA_W-1:0]   cm_data_o,
  output logic [DATA_W/8-1:0] cm_strb_o
);

  wr_state_e           state_q, state_d;
  logic [ADDR_W-3:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                aw_hs, w_hs;
  logic                unused_awaddr_lsb;

  assign unused_awaddr_lsb = ^awaddr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= W_IDLE;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      bresp_q <= bresp_d;
    end
  end

  // Holding registers for whichever half of the transaction arrived first
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    strb_d  = strb_q;
    bresp_d = bresp_q;
    case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          state_d = W_RESP;
        end else if (aw_hs) begin
          idx_d   = awaddr[ADDR_W-1:2];
          state_d = W_DATA;
        end else if (w_hs) begin
          data_d  = wdata;
          strb_d  = wstrb;
          state_d = W_ADDR;
        end
      end
      W_DATA:  if (w_hs)   state_d = W_RESP;
      W_ADDR:  if (aw_hs)  state_d = W_RESP;
      W_RESP:  if (bready) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
    if (commit_o) begin
      bresp_d = (32'(cm_idx_o) < NUM_REGS) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    commit_o  = 1'b0;
    cm_idx_o  = awaddr[ADDR_W-1:2];
    cm_data_o = wdata;
    cm_strb_o = wstrb;
    case (state_q)
      W_IDLE: begin
        awready  = en_i;
        wready   = en_i;
        commit_o = en_i && awvalid && wvalid;
      end
      W_DATA: begin
        wready   = en_i;
        commit_o = en_i && wvalid;
        cm_idx_o = idx_q;
      end
      W_ADDR: begin
        awready   = en_i;
        commit_o  = en_i && awvalid;
        cm_data_o = data_q;
        cm_strb_o = strb_q;
      end
      W_RESP:  bvalid = 1'b1;
      default: ;
    endcase
  end

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign bresp = bresp_q;

endmodule

// File: rtl/axil_csr_slave.sv
// AXI4-Lite CSR bank for the image-recognition pipeline: control, sticky event
// status with W1C, interrupt enable, ID and general configuration registers.
module axil_csr_slave
  import axil_csr_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 12,
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'h1A6E_0001
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic [7:0]                   event_i,
  output logic [31:0]                  ctrl_o,
  output logic [32*(NUM_REGS-4)-1:0]   cfg_o,
  output logic                         irq
);

  localparam int unsigned NUM_CFG = NUM_REGS - 4;

  logic                active_q, active_d;
  logic [31:0]         ctrl_q, ctrl_d;
  logic [7:0]          status_q, status_d, status_clr;
  logic [7:0]          irq_en_q, irq_en_d;
  logic [31:0]         cfg_q [NUM_CFG];
  logic [31:0]         cfg_d [NUM_CFG];
  logic                irq_q, irq_d;
  rd_state_e           rd_state_q, rd_state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                wr_commit;
  logic [ADDR_W-3:0]   wr_idx;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic [ADDR_W-3:0]   rd_idx;
  logic [31:0]         rd_val;
  logic                rd_ok;
  logic                ar_hs;
  logic                unused_araddr_lsb;

  assign unused_araddr_lsb = ^araddr[1:0];

  axil_csr_wr_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .en_i      (active_q),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .commit_o  (wr_commit),
    .cm_idx_o  (wr_idx),
    .cm_data_o (wr_data),
    .cm_strb_o (wr_strb)
  );

  // active_q keeps every ready low through reset and its first release edge
  assign active_d = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      ctrl_q   <= '0;
      status_q <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else begin
      active_q <= active_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      cfg_q    <= cfg_d;
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    irq_en_d   = irq_en_q;
    cfg_d      = cfg_q;
    status_clr = '0;
    if (wr_commit) begin
      if (32'(wr_idx) == IDX_CTRL) ctrl_d = byte_merge(ctrl_q, wr_data, wr_strb);
      if (32'(wr_idx) == IDX_STATUS && wr_strb[0]) status_clr = wr_data[7:0];
      if (32'(wr_idx) == IDX_IRQ_EN && wr_strb[0]) irq_en_d = wr_data[7:0];
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        if (32'(wr_idx) == i + IDX_CFG_BASE) cfg_d[i] = byte_merge(cfg_q[i], wr_data, wr_strb);
      end
    end
    // A new event in the same cycle as a W1C clear keeps the bit set
    status_d = (status_q & ~status_clr) | event_i;
    irq_d    = |(status_q & irq_en_q);
  end

  assign rd_idx = araddr[ADDR_W-1:2];

  always_comb begin
    rd_val = '0;
    rd_ok  = (32'(rd_idx) < NUM_REGS);
    if (32'(rd_idx) == IDX_CTRL)   rd_val = ctrl_q;
    if (32'(rd_idx) == IDX_STATUS) rd_val = {24'd0, status_q};
    if (32'(rd_idx) == IDX_IRQ_EN) rd_val = {24'd0, irq_en_q};
    if (32'(rd_idx) == IDX_ID)     rd_val = ID_VALUE;
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (32'(rd_idx) == i + IDX_CFG_BASE) rd_val = cfg_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_RESP;
          rdata_d    = rd_val;
          rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_RESP:  if (rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = active_q && (rd_state_q == R_IDLE);
    rvalid  = (rd_state_q == R_RESP);
    ar_hs   = arvalid && arready;
  end

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign ctrl_o = ctrl_q;
  assign irq    = irq_q;

  for (genvar g = 0; g < int'(NUM_CFG); g++) begin : g_cfg_out
    assign cfg_o[g*32 +: 32] = cfg_q[g];
  end

endmodule

// File: tb/tb_axil_csr_slave.sv
// Randomised scoreboard bench for axil_csr_slave: drivers push expected B/R
// responses from a register-map model, a monitor pops them on each handshake.
module tb_axil_csr_slave;

  logic         clk, reset;
  logic [11:0]  awaddr, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid, irq;
  logic [31:0]  wdata, rdata, ctrl_o;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [7:0]   event_i;
  logic [383:0] cfg_o;

  int checks = 0;
  int failures = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  logic [31:0] m_ctrl;
  logic [7:0]  m_status, m_irq_en;
  logic [31:0] m_cfg[12];

  logic        pb_v, pr_v;
  logic [1:0]  pb_r;
  logic [33:0] pr_r;

  axil_csr_slave dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .event_i(event_i), .ctrl_o(ctrl_o), .cfg_o(cfg_o), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference register map
  task automatic model_reset();
    m_ctrl = 0; m_status = 0; m_irq_en = 0;
    for (int i = 0; i < 12; i++) m_cfg[i] = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [33:0] model_read(input logic [11:0] a);
    int idx;
    idx = int'(a[11:2]);
    if (idx == 0) return {2'b00, m_ctrl};
    if (idx == 1) return {2'b00, 24'd0, m_status};
    if (idx == 2) return {2'b00, 24'd0, m_irq_en};
    if (idx == 3) return {2'b00, 32'h1A6E_0001};
    if (idx < 16) return {2'b00, m_cfg[idx-4]};
    return {2'b10, 32'd0};
  endfunction

  function automatic logic [1:0] model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[11:2]);
    if (idx >= 16) return 2'b10;
    if (idx == 0) m_ctrl = merge(m_ctrl, d, s);
    else if (idx == 1) begin if (s[0]) m_status = m_status & ~d[7:0]; end
    else if (idx == 2) begin if (s[0]) m_irq_en = d[7:0]; end
    else if (idx >= 4) m_cfg[idx-4] = merge(m_cfg[idx-4], d, s);
    return 2'b00;
  endfunction

  function automatic logic [383:0] model_cfg();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[i*32 +: 32] = m_cfg[i];
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_hs(input int which, input string nm);
    bit r;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      case (which)
        0: r = awready;
        1: r = wready;
        2: r = arready;
        3: r = bvalid;
        default: r = rvalid;
      endcase
      @(posedge clk); #1;
      n++;
    end while (!r && n < 50);
    if (!r) chk(nm, 0, 1);
  endtask

  task automatic axi_wr_raw(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd);
    fork
      begin idle(awd); awaddr = a; awvalid = 1'b1; wait_hs(0, "aw_timeout"); awvalid = 1'b0; end
      begin idle(wd); wdata = d; wstrb = s; wvalid = 1'b1; wait_hs(1, "w_timeout"); wvalid = 1'b0; end
    join
    chk("bvalid_latency", bvalid, 1);
    idle(bd);
    bready = 1'b1;
    wait_hs(3, "b_timeout");
    bready = 1'b0;
  endtask

  task automatic axi_rd_raw(input logic [11:0] a, input int ard, input int rd);
    idle(ard);
    araddr = a; arvalid = 1'b1;
    wait_hs(2, "ar_timeout");
    arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1);
    idle(rd);
    rready = 1'b1;
    wait_hs(4, "r_timeout");
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd);
    exp_b.push_back(model_write(a, d, s));
    axi_wr_raw(a, d, s, awd, wd, bd);
  endtask

  task automatic axi_read(input logic [11:0] a, input int ard, input int rd);
    exp_r.push_back(model_read(a));
    axi_rd_raw(a, ard, rd);
  endtask

  task automatic chk_regs(input string nm);
    chk({nm, "_ctrl"}, ctrl_o, m_ctrl);
    chk({nm, "_cfg"}, cfg_o, model_cfg());
    chk({nm, "_irq"}, irq, |(m_status & m_irq_en));
  endtask

  task automatic chk_readies(input string nm, input logic v);
    chk({nm, "_awready"}, awready, v);
    chk({nm, "_wready"}, wready, v);
    chk({nm, "_arready"}, arready, v);
  endtask

  // Response monitor: pops the scoreboard on each B/R handshake and checks hold-while-stalled
  always @(negedge clk) begin
    if (reset) begin
      pb_v = 1'b0;
      pr_v = 1'b0;
    end else begin
      if (pb_v) begin
        chk("b_hold_valid", bvalid, 1);
        chk("b_hold_resp", bresp, pb_r);
      end
      if (pr_v) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", {rresp, rdata}, pr_r);
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", bresp, exp_b.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else chk("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
      end
      pb_v = bvalid && !bready;
      pb_r = bresp;
      pr_v = rvalid && !rready;
      pr_r = {rresp, rdata};
    end
  end

  initial begin
    reset = 1'b1;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; event_i = 0;
    pb_v = 0; pr_v = 0; pb_r = 0; pr_r = 0;
    model_reset();

    idle(3);
    chk_readies("rst", 1'b0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_resp", {bresp, rresp, rdata}, 0);
    chk_regs("rst");
    reset = 1'b0;
    idle(1);
    chk_readies("rel", 1'b1);

    axi_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk_regs("wr_cfg0");

    axi_write(12'h000, 32'h12345678, 4'h3, 0, 3, 4);
    chk("ctrl_strb", ctrl_o, 32'h0000_5678);

    axi_read(12'h00C, 0, 0);
    axi_read(12'h040, 0, 2);
    axi_write(12'h040, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
    chk_regs("unmapped_wr");

    // Event to sticky status to registered irq
    axi_write(12'h008, 32'h1, 4'h1, 0, 0, 0);
    event_i = 8'h01;
    idle(1);
    event_i = 8'h00;
    chk("irq_not_yet", irq, 0);
    m_status = m_status | 8'h01;
    idle(1);
    chk("irq_set", irq, 1);
    axi_read(12'h004, 0, 0);
    axi_write(12'h004, 32'h1, 4'h1, 0, 0, 0);
    chk("irq_cleared", irq, 0);
    fork
      axi_write(12'h004, 32'h1, 4'h1, 0, 0, 0);
      begin event_i = 8'h01; idle(1); event_i = 8'h00; end
    join
    m_status = m_status | 8'h01;
    axi_read(12'h004, 0, 0);
    chk("irq_set_wins", irq, 1);

    // Read and write of the same register on one edge
    exp_r.push_back(model_read(12'h010));
    exp_b.push_back(model_write(12'h010, 32'h55, 4'hF));
    fork
      axi_wr_raw(12'h010, 32'h55, 4'hF, 0, 0, 0);
      axi_rd_raw(12'h010, 0, 0);
    join
    axi_read(12'h010, 0, 0);

    for (int n = 0; n < 80; n++) begin
      logic [11:0] a;
      a = {$urandom_range(0, 17), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        chk_regs("rand_wr");
      end else begin
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    // Reset while a write response is pending
    awaddr = 12'h014; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    idle(1);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pend_bvalid", bvalid, 1);
    reset = 1'b1;
    idle(1);
    model_reset();
    chk("midrst_bvalid", bvalid, 0);
    chk_readies("midrst", 1'b0);
    chk_regs("midrst");
    reset = 1'b0;
    idle(1);
    chk_readies("midrel", 1'b1);
    axi_read(12'h014, 0, 0);
    axi_read(12'h004, 0, 0);
    idle(2);
    chk("b_queue_empty", exp_b.size(), 0);
    chk("r_queue_empty", exp_r.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
